// File: rtl/loong_pkg.sv
// loong_pkg: shared types and constants for the LOONG round sequencer.
//   rctl_state_t   : round controller state encoding
//   RC_IDX_W       : width of the round index driven to the constant generator
//   NUM_ROUNDS_DEF : default number of rounds per block
package loong_pkg;

    localparam int unsigned RC_IDX_W       = 6;
    localparam int unsigned NUM_ROUNDS_DEF = 33;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        RC_WAIT  = 3'd2,
        FIRE     = 3'd3,
        ACK_WAIT = 3'd4,
        FINISH   = 3'd5
    } rctl_state_t;

endpackage

// File: rtl/loong_round_ctrl_wdog.sv
// loong_wdog: acknowledge watchdog for the round controller.
//   clock   : system clock, rising edge
//   rst     : synchronous active-low reset (counter cleared to 0)
//   clear   : load the counter; asserted in the cycle round_go is high
//   en      : count down; asserted while waiting for round_ack
//   expired : high in the last waiting cycle, so the error is visible
//             exactly ACK_TIMEOUT cycles after the round_go cycle
// ACK_TIMEOUT must be at least 2.
module loong_wdog #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned W           = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    // The round_go cycle itself is not spent in the wait, hence the -1.
    localparam logic [W-1:0] LOAD_VAL = W'(ACK_TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    // Loadable saturating down-counter.
    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expired = en && (cnt_q <= W'(1));

endmodule

// File: rtl/loong_round_ctrl.sv
// loong_round_ctrl: round sequencer for the LOONG cipher core.
// Steps round index j through 0..NUM_ROUNDS-1. For each round it waits out a
// settle window, waits for rc_done, pulses round_go and waits for round_ack,
// with a watchdog on the acknowledge.
// Ports:
//   clock      : system clock, rising edge
//   rst        : synchronous active-low reset
//   start      : level, sampled only in IDLE, begins a block
//   j          : round index to the constant generator
//   rc_done    : constant-valid from the generator
//   round_go   : one-cycle pulse executing one round
//   round_ack  : datapath round complete
//   last_round : j == NUM_ROUNDS-1 while busy
//   busy       : high outside IDLE
//   done       : one-cycle pulse on block completion
//   err        : sticky watchdog error, cleared by start or reset
//   abort      : (only with LOONG_ABORT_EN) abandons the block
// Optional feature macro: LOONG_ABORT_EN.
module loong_round_ctrl
    import loong_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS  = NUM_ROUNDS_DEF,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    output logic [RC_IDX_W-1:0] j,
    input  logic                rc_done,
    output logic                round_go,
    input  logic                round_ack,
`ifdef LOONG_ABORT_EN
    input  logic                abort,
`endif
    output logic                last_round,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned          SET_W       = $clog2(SETTLE_CYC + 1);
    localparam int unsigned          WD_W        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SET_W-1:0]     SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [RC_IDX_W-1:0]  LAST_J      = RC_IDX_W'(NUM_ROUNDS - 1);

    rctl_state_t         state_q, state_d;
    logic [RC_IDX_W-1:0] j_q, j_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic                err_q, err_d;
    logic                round_go_q, done_q, busy_q, last_round_q;
    logic                wd_expired_s;

    loong_wdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .W           (WD_W)
    ) u_wdog (
        .clock   (clock),
        .rst     (rst),
        .clear   (state_q == FIRE),
        .en      (state_q == ACK_WAIT),
        .expired (wd_expired_s)
    );

    // Next-state and datapath update decisions.
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        settle_d = settle_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    j_d      = '0;
                    err_d    = 1'b0;
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                // rc_done is deliberately not looked at here.
                if (settle_q == '0) begin
                    state_d = RC_WAIT;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            RC_WAIT: begin
                if (rc_done) begin
                    state_d = FIRE;
                end else begin
                    state_d = RC_WAIT;
                end
            end
            FIRE: begin
                state_d = ACK_WAIT;
            end
            ACK_WAIT: begin
                // Ack is checked first so it beats a same-cycle expiry.
                if (round_ack) begin
                    if (j_q == LAST_J) begin
                        state_d = FINISH;
                    end else begin
                        j_d      = j_q + RC_IDX_W'(1);
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end
                end else if (wd_expired_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ACK_WAIT;
                end
            end
            FINISH: begin
                j_d     = '0;
                state_d = IDLE;
            end
            default: begin
                j_d     = '0;
                state_d = IDLE;
            end
        endcase
`ifdef LOONG_ABORT_EN
        // Abort overrides ack and watchdog; err keeps its current value.
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            j_d      = '0;
            settle_d = '0;
            err_d    = err_q;
        end else begin
            state_d = state_d;
        end
`endif
    end

    // State register with registered handshake outputs derived from next state.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q      <= IDLE;
            j_q          <= '0;
            settle_q     <= '0;
            err_q        <= 1'b0;
            round_go_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            last_round_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            j_q          <= j_d;
            settle_q     <= settle_d;
            err_q        <= err_d;
            round_go_q   <= (state_d == FIRE);
            done_q       <= (state_d == FINISH);
            busy_q       <= (state_d != IDLE);
            last_round_q <= (state_d != IDLE) && (j_d == LAST_J);
        end
    end

    assign j          = j_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign last_round = last_round_q;
`ifdef LOONG_ABORT_EN
    // round_go is registered on entry to FIRE, so an abort arriving during
    // FIRE has to mask it on the way out.
    assign round_go   = round_go_q & ~abort;
`else
    assign round_go   = round_go_q;
`endif

endmodule

// File: tb/tb_loong_round_ctrl.sv
module tb_loong_round_ctrl;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] j;
    logic       rc_done = 1'b0;
    logic       round_go;
    logic       round_ack = 1'b0;
    logic       last_round;
    logic       busy;
    logic       done;
    logic       err;
`ifdef LOONG_ABORT_EN
    logic       abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    loong_round_ctrl dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .j          (j),
        .rc_done    (rc_done),
        .round_go   (round_go),
        .round_ack  (round_ack),
`ifdef LOONG_ABORT_EN
        .abort      (abort),
`endif
        .last_round (last_round),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; start = 1'b0; rc_done = 1'b0; round_ack = 1'b0;
`ifdef LOONG_ABORT_EN
        abort = 1'b0;
`endif
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (j !== 6'd0) begin errors++; $display("FAIL rst_j: got %0d want 0", j); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (round_go !== 1'b0) begin errors++; $display("FAIL rst_go: got %b want 0", round_go); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (last_round !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", last_round); end
    endtask

    task automatic test_nominal();
        int gos = 0;
        int dones = 0;
        logic prev_go = 1'b0;
        logic overlap = 1'b0;
        logic lr_bad = 1'b0;
        logic lr_at_done = 1'b0;
        logic [5:0] exp_j = 6'd0;
        start = 1'b1; rc_done = 1'b0; round_ack = 1'b0;
        for (int cyc = 0; cyc < 2000 && dones == 0; cyc++) begin
            tick();
            start = 1'b0;
            if (round_go && done) overlap = 1'b1;
            if (last_round && (exp_j < 6'd32)) lr_bad = 1'b1;
            if (round_go) begin
                checks++; if (j !== exp_j) begin errors++; $display("FAIL nom_j: got %0d want %0d", j, exp_j); end
                checks++; if (last_round !== (exp_j == 6'd32)) begin errors++; $display("FAIL nom_last: got %b at j %0d", last_round, exp_j); end
                exp_j = exp_j + 6'd1;
                gos++;
            end
            if (done) begin dones++; lr_at_done = last_round; end
            // Ack comes one cycle after round_go; rc_done toggles every cycle.
            round_ack = prev_go;
            prev_go = round_go;
            rc_done = cyc[0];
        end
        rc_done = 1'b0; round_ack = 1'b0;
        checks++; if (gos !== 33) begin errors++; $display("FAIL nom_gos: got %0d want 33", gos); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL nom_done: got %0d want 1", dones); end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL nom_overlap: got %b want 0", overlap); end
        checks++; if (lr_bad !== 1'b0) begin errors++; $display("FAIL nom_last_early: got %b want 0", lr_bad); end
        checks++; if (lr_at_done !== 1'b1) begin errors++; $display("FAIL nom_last_fin: got %b want 1", lr_at_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nom_err: got %b want 0", err); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_after: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL nom_done_width: got %b want 0", done); end
        checks++; if (j !== 6'd0) begin errors++; $display("FAIL nom_j_after: got %0d want 0", j); end
        checks++; if (last_round !== 1'b0) begin errors++; $display("FAIL nom_last_after: got %b want 0", last_round); end
    endtask

    task automatic test_settle_latency();
        int n = 0;
        int last_chg = 1;
        int gos = 0;
        logic gap_bad = 1'b0;
        logic seen_done = 1'b0;
        logic [5:0] prev_j = 6'd0;
        rc_done = 1'b1; round_ack = 1'b1; start = 1'b1;
        while (n < 1000 && !seen_done) begin
            tick();
            n++;
            start = 1'b0;
            if (j !== prev_j) begin last_chg = n; prev_j = j; end
            // Two masked settle cycles plus one RC_WAIT cycle before FIRE.
            if (round_go) begin gos++; if ((n - last_chg) != 3) gap_bad = 1'b1; end
            if (done) seen_done = 1'b1;
        end
        rc_done = 1'b0; round_ack = 1'b0;
        checks++; if (n !== 166) begin errors++; $display("FAIL lat_cycles: got %0d want 166", n); end
        checks++; if (gos !== 33) begin errors++; $display("FAIL lat_gos: got %0d want 33", gos); end
        checks++; if (gap_bad !== 1'b0) begin errors++; $display("FAIL lat_settle_gap: got %b want 0", gap_bad); end
        tick();
    endtask

    task automatic test_watchdog();
        logic found = 1'b0;
        logic early = 1'b0;
        logic seen_done = 1'b0;
        rc_done = 1'b1; round_ack = 1'b1; start = 1'b1;
        for (int n = 0; n < 500 && !found; n++) begin
            tick();
            start = 1'b0;
            if (round_go && (j == 6'd5)) begin found = 1'b1; round_ack = 1'b0; end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL wd_reach_j5: got %b want 1", found); end
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (done) seen_done = 1'b1;
            if ((k < 15) && (err || !busy)) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL wd_early: got %b want 0", early); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err: got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy: got %b want 0", busy); end
        checks++; if (j !== 6'd5) begin errors++; $display("FAIL wd_j: got %0d want 5", j); end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL wd_done: got %b want 0", seen_done); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", err); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b want 0", err); end
        checks++; if (j !== 6'd0) begin errors++; $display("FAIL wd_restart_j: got %0d want 0", j); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_restart_busy: got %b want 1", busy); end
        apply_reset();
    endtask

    task automatic test_reset_mid_block();
        logic found = 1'b0;
        logic seen_done = 1'b0;
        rc_done = 1'b1; round_ack = 1'b1; start = 1'b1;
        for (int n = 0; n < 500 && !found; n++) begin
            tick();
            start = 1'b0;
            if (round_go && (j == 6'd10)) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach_j10: got %b want 1", found); end
        tick();
        // Now in ACK_WAIT with ack high; reset must win.
        rst = 1'b0;
        tick();
        rst = 1'b1; rc_done = 1'b0; round_ack = 1'b0;
        checks++; if (j !== 6'd0) begin errors++; $display("FAIL mid_j: got %0d want 0", j); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (round_go !== 1'b0) begin errors++; $display("FAIL mid_go: got %b want 0", round_go); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err); end
        checks++; if (last_round !== 1'b0) begin errors++; $display("FAIL mid_last: got %b want 0", last_round); end
        for (int k = 0; k < 6; k++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", seen_done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_restart: got %b want 1", busy); end
        apply_reset();
    endtask

    task automatic test_spurious();
        logic go_seen = 1'b0;
        // Ack held high while the controller sits in RC_WAIT.
        rc_done = 1'b0; round_ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (round_go) go_seen = 1'b1;
        end
        checks++; if (go_seen !== 1'b0) begin errors++; $display("FAIL sp_ack_go: got %b want 0", go_seen); end
        checks++; if (j !== 6'd0) begin errors++; $display("FAIL sp_ack_j: got %0d want 0", j); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sp_ack_busy: got %b want 1", busy); end
        rc_done = 1'b1;
        tick();
        rc_done = 1'b0;
        checks++; if (round_go !== 1'b1) begin errors++; $display("FAIL sp_fire: got %b want 1", round_go); end
        tick();
        tick();
        checks++; if (j !== 6'd1) begin errors++; $display("FAIL sp_step: got %0d want 1", j); end
        // start while busy must not restart the block.
        round_ack = 1'b0; start = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        start = 1'b0;
        checks++; if (j !== 6'd1) begin errors++; $display("FAIL sp_start_busy: got %0d want 1", j); end
        // Ack arrives in the very cycle the watchdog expires.
        rc_done = 1'b1;
        tick();
        rc_done = 1'b0;
        checks++; if (round_go !== 1'b1) begin errors++; $display("FAIL sp_fire2: got %b want 1", round_go); end
        for (int k = 1; k <= 13; k++) tick();
        tick();
        round_ack = 1'b1;
        tick();
        round_ack = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sp_race_err: got %b want 0", err); end
        checks++; if (j !== 6'd2) begin errors++; $display("FAIL sp_race_j: got %0d want 2", j); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sp_race_busy: got %b want 1", busy); end
        apply_reset();
    endtask

`ifdef LOONG_ABORT_EN
    task automatic test_abort();
        logic found = 1'b0;
        rc_done = 1'b1; round_ack = 1'b1; start = 1'b1;
        for (int n = 0; n < 500 && !found; n++) begin
            tick();
            start = 1'b0;
            if (j == 6'd3) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL ab_reach_j3: got %b want 1", found); end
        tick();
        tick();
        abort = 1'b1;
        #1;
        checks++; if (round_go !== 1'b0) begin errors++; $display("FAIL ab_go: got %b want 0", round_go); end
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b want 0", busy); end
        checks++; if (j !== 6'd0) begin errors++; $display("FAIL ab_j: got %0d want 0", j); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ab_err: got %b want 0", err); end
        apply_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_settle_latency();
        test_watchdog();
        test_reset_mid_block();
        test_spurious();
`ifdef LOONG_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
